// File: rtl/audio_player.sv
// audio_player: sound-effect playback engine.
// Steps the sound ROM at the sample rate, holds each returned 8-bit unsigned
// PCM byte as the PWM duty and drives a 1-bit speaker output.
//
// Optional feature macro: AUDIO_PLAYER_PREEMPT_EN
//   defined   : a request whose id >= the playing id restarts playback
//   undefined : requests during playback are ignored
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   play_req     one-cycle play request strobe
//   play_id      sound id (1 jump, 2 dead, 3 win, 0 ignored)
//   rom_address  ROM sample address (registered)
//   rom_select   ROM sound select (registered)
//   rom_data     ROM byte, valid two cycles after address/select change
//   pwm_out      PWM speaker drive (registered)
//   busy         high while a sound plays
//   done         one-cycle pulse when a sound completes naturally
module audio_player #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned SAMPLE_HZ = 16_000,
    parameter logic [16:0] LEN_JUMP  = 17'd8000,
    parameter logic [16:0] LEN_DEAD  = 17'd16000,
    parameter logic [16:0] LEN_WIN   = 17'd32000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play_req,
    input  logic [1:0]  play_id,
    output logic [16:0] rom_address,
    output logic [1:0]  rom_select,
    input  logic [7:0]  rom_data,
    output logic        pwm_out,
    output logic        busy,
    output logic        done
);

    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned DIV      = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_MID = SAMPLE_W'(8'h80);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    logic [0:0]          state,    state_d;
    logic [ADDR_W-1:0]   len_q,    len_d;
    logic [DIV_W-1:0]    div_cnt,  div_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [SEL_W-1:0]    sel_d;
    logic                busy_d, done_d;
    logic [SAMPLE_W-1:0] pwm_cnt;

    logic                req_valid;
    logic                preempt;
    logic                tick;
    logic [ADDR_W-1:0]   len_req;

    assign req_valid = play_req && (play_id != SEL_W'(0));
    assign tick      = (div_cnt == DIV_LAST);

`ifdef AUDIO_PLAYER_PREEMPT_EN
    // Equal or higher priority id restarts the current sound.
    assign preempt = req_valid && (play_id >= rom_select);
`else
    assign preempt = 1'b0;
`endif

    // Sound length for the requested id.
    always_comb begin
        len_req = LEN_WIN;
        case (play_id)
            2'd1:    len_req = LEN_JUMP;
            2'd2:    len_req = LEN_DEAD;
            default: len_req = LEN_WIN;
        endcase
    end

    // State register and playback datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_q       <= '0;
            div_cnt     <= '0;
            sample_q    <= SAMPLE_MID;
            rom_address <= '0;
            rom_select  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            len_q       <= len_d;
            div_cnt     <= div_d;
            sample_q    <= sample_d;
            rom_address <= addr_d;
            rom_select  <= sel_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        len_d    = len_q;
        div_d    = div_cnt;
        sample_d = sample_q;
        addr_d   = rom_address;
        sel_d    = rom_select;
        busy_d   = busy;
        done_d   = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_d = PLAY;
                    sel_d   = play_id;
                    addr_d  = '0;
                    div_d   = '0;
                    len_d   = len_req;
                    busy_d  = 1'b1;
                end
            end
            PLAY: begin
                if (preempt) begin
                    // Restart without a done pulse; sample keeps playing
                    // until the new sound's first tick.
                    sel_d  = play_id;
                    addr_d = '0;
                    div_d  = '0;
                    len_d  = len_req;
                end else if (tick) begin
                    div_d = '0;
                    if (rom_address == len_q - ADDR_W'(1)) begin
                        state_d  = IDLE;
                        sel_d    = '0;
                        addr_d   = '0;
                        sample_d = SAMPLE_MID;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        sample_d = rom_data;
                        addr_d   = rom_address + ADDR_W'(1);
                    end
                end else begin
                    div_d = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Free-running PWM carrier compared against the held sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + SAMPLE_W'(1);
            pwm_out <= (pwm_cnt < sample_q);
        end
    end

endmodule

// File: tb/tb_audio_player.sv
// Bench for audio_player: time-based reference model checked every cycle,
// plus hand-computed latency and duty expectations.
module tb_audio_player;

    localparam int unsigned CLK_HZ    = 800;
    localparam int unsigned SAMPLE_HZ = 100;
    localparam int unsigned DIV       = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned LEN_J     = 4;
    localparam int unsigned LEN_D     = 6;
    localparam int unsigned LEN_W     = 3;
`ifdef AUDIO_PLAYER_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        play_req = 1'b0;
    logic [1:0]  play_id  = 2'd0;
    logic [16:0] rom_address;
    logic [1:0]  rom_select;
    logic [7:0]  rom_data = 8'h00;
    logic        pwm_out;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    int done_cnt = 0;
    bit saw_win  = 1'b0;

    bit         force_en  = 1'b0;
    logic [7:0] force_val = 8'h00;
    logic [7:0] rom_d1    = 8'h00;

    audio_player #(
        .CLK_HZ   (CLK_HZ),
        .SAMPLE_HZ(SAMPLE_HZ),
        .LEN_JUMP (17'(LEN_J)),
        .LEN_DEAD (17'(LEN_D)),
        .LEN_WIN  (17'(LEN_W))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .play_req   (play_req),
        .play_id    (play_id),
        .rom_address(rom_address),
        .rom_select (rom_select),
        .rom_data   (rom_data),
        .pwm_out    (pwm_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_fn(input logic [1:0] s, input logic [16:0] a);
        return force_en ? force_val : {s, a[5:0]};
    endfunction

    // ROM with two register stages of latency.
    always @(posedge clk) begin
        rom_d1   <= rom_fn(rom_select, rom_address);
        rom_data <= rom_d1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: position in playback is elapsed cycles since accept.
    int unsigned m_n = 0;
    int unsigned m_e = 0;
    int unsigned m_len = 0;
    bit          m_play = 1'b0;
    logic [1:0]  m_sel = 2'd0;
    logic [16:0] m_addr = 17'd0;
    logic [7:0]  m_sample = 8'h80;
    bit          m_done = 1'b0;
    bit          m_pwm = 1'b0;

    function automatic int unsigned len_of(input logic [1:0] id);
        case (id)
            2'd1:    return LEN_J;
            2'd2:    return LEN_D;
            default: return LEN_W;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_e = 0; m_len = 0; m_play = 1'b0; m_sel = 2'd0;
            m_addr = 17'd0; m_sample = 8'h80; m_done = 1'b0; m_pwm = 1'b0;
        end else begin
            m_pwm = ((m_n % 256) < m_sample);
            m_n++;
            m_done = 1'b0;
            if (play_req && play_id != 2'd0 &&
                (!m_play || (PREEMPT && play_id >= m_sel))) begin
                m_play = 1'b1; m_sel = play_id; m_e = 0; m_addr = 17'd0;
                m_len = len_of(play_id);
            end else if (m_play) begin
                m_e++;
                if (m_e % DIV == 0) begin
                    if (m_e / DIV == m_len) begin
                        m_play = 1'b0; m_sel = 2'd0; m_addr = 17'd0;
                        m_sample = 8'h80; m_done = 1'b1;
                    end else begin
                        m_sample = rom_fn(m_sel, 17'(m_e / DIV - 1));
                        m_addr   = 17'(m_e / DIV);
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus event bookkeeping.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rom_address", 32'(rom_address), 32'(m_addr));
            check("rom_select",  32'(rom_select),  32'(m_sel));
            check("busy",        32'(busy),        32'(m_play));
            check("done",        32'(done),        32'(m_done));
            check("pwm_out",     32'(pwm_out),     32'(m_pwm));
            if (done) done_cnt++;
            if (rom_select == 2'd3) saw_win = 1'b1;
        end
    end

    task automatic req(input logic [1:0] id);
        play_req = 1'b1;
        play_id  = id;
        @(negedge clk);
        play_req = 1'b0;
        play_id  = 2'd0;
    endtask

    task automatic wait_done(input int lim, output int unsigned at);
        bit ok;
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        check("done_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned t0, t1, td;
        int hi, dc0;

        // Reset values.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(rom_address), 32'd0);
        check("rst_sel",  32'(rom_select),  32'd0);
        check("rst_busy", 32'(busy),        32'd0);
        check("rst_done", 32'(done),        32'd0);
        rst_n = 1'b1;

        // Idle duty with mid-scale sample: 128 of 256.
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(pwm_out);
        end
        check("reset_duty", 32'(hi), 32'd128);

        // Jump playback latency.
        req(2'd1);
        t0 = cyc;
        check("jump_sel",  32'(rom_select), 32'd1);
        check("jump_busy", 32'(busy),       32'd1);
        wait_done(60, td);
        check("jump_done_lat", td - t0, 32'(LEN_J * DIV));
        @(negedge clk);
        check("jump_busy_low", 32'(busy), 32'd0);

        // id 0 ignored in idle.
        repeat (3) @(negedge clk);
        req(2'd0);
        check("id0_busy", 32'(busy),       32'd0);
        check("id0_sel",  32'(rom_select), 32'd0);
        repeat (3) @(negedge clk);

        // Full-scale duty: 0x00 then 0xFF.
        force_en  = 1'b1;
        force_val = 8'h00;
        repeat (4) @(negedge clk);
        req(2'd1);
        repeat (8) @(negedge clk);
        hi = 0;
        repeat (24) begin
            @(negedge clk);
            hi += int'(pwm_out);
        end
        check("duty_00", 32'(hi), 32'd0);
        repeat (4) @(negedge clk);
        force_val = 8'hFF;
        repeat (4) @(negedge clk);
        req(2'd1);
        repeat (8) @(negedge clk);
        hi = 0;
        repeat (24) begin
            @(negedge clk);
            hi += int'(pwm_out);
        end
        check("duty_ff_ge23", 32'(hi >= 23), 32'd1);
        repeat (4) @(negedge clk);
        force_en = 1'b0;
        repeat (4) @(negedge clk);

        // Win request ten cycles into jump playback.
        saw_win = 1'b0;
        dc0 = done_cnt;
        req(2'd1);
        t0 = cyc;
        repeat (9) @(negedge clk);
        req(2'd3);
        wait_done(60, td);
        check("pre_done_lat", td - t0, PREEMPT ? 32'd34 : 32'd32);
        repeat (40) @(negedge clk);
        check("pre_done_cnt", 32'(done_cnt - dc0), 32'd1);
        check("pre_saw_win",  32'(saw_win), 32'(PREEMPT));

        // Asynchronous reset in the middle of dead playback.
        dc0 = done_cnt;
        req(2'd2);
        repeat (11) @(negedge clk);
        check("dead_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_addr", 32'(rom_address), 32'd0);
        check("arst_sel",  32'(rom_select),  32'd0);
        check("arst_busy", 32'(busy),        32'd0);
        check("arst_done", 32'(done),        32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_no_done", 32'(done_cnt - dc0), 32'd0);
        req(2'd1);
        t1 = cyc;
        wait_done(60, td);
        check("post_rst_lat", td - t1, 32'(LEN_J * DIV));

        // Random request traffic against the model.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            play_req = ($urandom_range(0, 7) == 0);
            play_id  = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        play_req = 1'b0;
        play_id  = 2'd0;
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
